// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the phase encoding used by the
// horizontal and vertical sequencers.
package vga_pkg;

  // 640x480 @ 60 Hz from a 50 MHz board clock
  localparam int DEF_PIX_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef enum logic [1:0] {
    VIS = 2'd0,
    FP  = 2'd1,
    SY  = 2'd2,
    BP  = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate enable generator: one-clock pulse every PIX_DIV enabled clocks.
// The count freezes while enable is low so a pending tick is not lost.
module vga_pixel_tick #(
  parameter int PIX_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic pix_tick
);

  localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

  generate
    if (PIX_DIV < 1) begin : g_div_check
      $error("vga_pixel_tick: PIX_DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Gated combinationally so the tick drops the same cycle enable or reset does
  assign pix_tick = enable & ~reset & (cnt == LAST);

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel divider, horizontal/vertical phase FSMs, and
// registered sync/blank/coordinate/strobe outputs aligned with x,y.
module vga_timing_controller
  import vga_pkg::*;
#(
  parameter int   PIX_DIV     = DEF_PIX_DIV,
  parameter int   H_VISIBLE   = DEF_H_VISIBLE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_VISIBLE   = DEF_V_VISIBLE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (HT > COORD_MAX || VT > COORD_MAX) begin : g_total_check
      $error("vga_timing_controller: line or frame total exceeds counter range");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_FP_AT = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] H_SY_AT = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] H_BP_AT = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] V_FP_AT = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] V_SY_AT = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] V_BP_AT = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(VT - 1);

  phase_t             h_st, h_nxt;
  phase_t             v_st, v_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               adv, x_wrap, y_wrap;

  vga_pixel_tick #(
    .PIX_DIV(PIX_DIV)
  ) u_pixel_tick (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .pix_tick(pix_tick)
  );

  assign adv    = pix_tick;
  assign x_wrap = (x == H_LAST);
  assign y_wrap = (y == V_LAST);

  // Next raster position and phases; the vertical FSM only moves on a line wrap
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    h_nxt = h_st;
    v_nxt = v_st;
    if (adv) begin
      x_nxt = x_wrap ? '0 : x + COORD_W'(1);
      if (x_wrap) begin
        y_nxt = y_wrap ? '0 : y + COORD_W'(1);
      end
      case (h_st)
        VIS:     if (x_nxt == H_FP_AT) h_nxt = FP;
        FP:      if (x_nxt == H_SY_AT) h_nxt = SY;
        SY:      if (x_nxt == H_BP_AT) h_nxt = BP;
        BP:      if (x_wrap)           h_nxt = VIS;
        default:                       h_nxt = VIS;
      endcase
      if (x_wrap) begin
        case (v_st)
          VIS:     if (y_nxt == V_FP_AT) v_nxt = FP;
          FP:      if (y_nxt == V_SY_AT) v_nxt = SY;
          SY:      if (y_nxt == V_BP_AT) v_nxt = BP;
          BP:      if (y_wrap)           v_nxt = VIS;
          default:                       v_nxt = VIS;
        endcase
      end
    end
  end

  // Outputs decode the next state so they change on the same edge as x,y
  always_ff @(posedge clock) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      h_st        <= VIS;
      v_st        <= VIS;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= adv & x_wrap;
      frame_start <= adv & x_wrap & y_wrap;
      if (enable) begin
        x        <= x_nxt;
        y        <= y_nxt;
        h_st     <= h_nxt;
        v_st     <= v_nxt;
        hsync    <= (h_nxt == SY) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync    <= (v_nxt == SY) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on <= (h_nxt == VIS) && (v_nxt == VIS);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: default 640x480 build, a
// PIX_DIV=1 active-high-sync build, and a shrunken-raster build for frame wraps.
module tb_vga_timing_controller;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       a_rst, a_en, a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_rst, b_en, b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic       c_rst, c_en, c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic [9:0] c_x, c_y;

  vga_timing_controller u_a (
    .clock(clock), .reset(a_rst), .enable(a_en), .pix_tick(a_tick),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .x(a_x), .y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_controller #(.PIX_DIV(1), .SYNC_ACTIVE(1'b1)) u_b (
    .clock(clock), .reset(b_rst), .enable(b_en), .pix_tick(b_tick),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_controller #(
    .PIX_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_c (
    .clock(clock), .reset(c_rst), .enable(c_en), .pix_tick(c_tick),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .x(c_x), .y(c_y),
    .line_start(c_ls), .frame_start(c_fs)
  );

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  typedef struct {
    int   dut;
    int   n;
    obs_t e;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t sample(int d);
    obs_t o;
    case (d)
      0:       o = {a_tick, a_hs, a_vs, a_von, a_ls, a_fs, a_x, a_y};
      1:       o = {b_tick, b_hs, b_vs, b_von, b_ls, b_fs, b_x, b_y};
      default: o = {c_tick, c_hs, c_vs, c_von, c_ls, c_fs, c_x, c_y};
    endcase
    return o;
  endfunction

  function automatic obs_t mk_obs(logic tick, int xv, int yv, logic hs, logic vs,
                                  logic von, logic ls, logic fs);
    obs_t o;
    o = {tick, hs, vs, von, ls, fs, 10'(xv), 10'(yv)};
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("tick=%b hs=%b vs=%b von=%b ls=%b fs=%b x=%0d y=%0d",
                     o.tick, o.hs, o.vs, o.von, o.ls, o.fs, o.x, o.y);
  endfunction

  task automatic add(int d, int n, logic tick, int xv, int yv, logic hs, logic vs,
                     logic von, logic ls, logic fs);
    vec_t v;
    v.dut = d;
    v.n   = n;
    v.e   = mk_obs(tick, xv, yv, hs, vs, von, ls, fs);
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_obs(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual {%s} expected {%s}", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_table(int d, int n);
    foreach (vt[i]) begin
      if (vt[i].dut == d && vt[i].n == n)
        chk_obs($sformatf("vec_dut%0d_n%0d", d, n), sample(d), vt[i].e);
    end
  endtask

  initial begin
    int von_cnt, hs_cnt, ls1, ls2, viol, k, vs_cnt, fs_cnt, fs_first, fs_second;
    int tick_low, ls_first, ls_second, hs_hi;
    logic hs_hold;

    // dut, n (edges after reset release), tick, x, y, hs, vs, von, ls, fs
    add(0,    0, 0,   0, 0, 1, 1, 0, 0, 0);
    add(0,    1, 1,   0, 0, 1, 1, 1, 0, 0);
    add(0,    2, 0,   1, 0, 1, 1, 1, 0, 0);
    add(0,    3, 1,   1, 0, 1, 1, 1, 0, 0);
    add(0, 1279, 1, 639, 0, 1, 1, 1, 0, 0);
    add(0, 1280, 0, 640, 0, 1, 1, 0, 0, 0);
    add(0, 1311, 1, 655, 0, 1, 1, 0, 0, 0);
    add(0, 1312, 0, 656, 0, 0, 1, 0, 0, 0);
    add(0, 1503, 1, 751, 0, 0, 1, 0, 0, 0);
    add(0, 1504, 0, 752, 0, 1, 1, 0, 0, 0);
    add(0, 1599, 1, 799, 0, 1, 1, 0, 0, 0);
    add(0, 1600, 0,   0, 1, 1, 1, 1, 1, 0);
    add(0, 1601, 1,   0, 1, 1, 1, 1, 0, 0);
    add(1,    0, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1,    1, 1,   1, 0, 0, 0, 1, 0, 0);
    add(1,  639, 1, 639, 0, 0, 0, 1, 0, 0);
    add(1,  640, 1, 640, 0, 0, 0, 0, 0, 0);
    add(1,  655, 1, 655, 0, 0, 0, 0, 0, 0);
    add(1,  656, 1, 656, 0, 1, 0, 0, 0, 0);
    add(1,  751, 1, 751, 0, 1, 0, 0, 0, 0);
    add(1,  752, 1, 752, 0, 0, 0, 0, 0, 0);
    add(1,  800, 1,   0, 1, 0, 0, 1, 1, 0);
    add(2,    0, 0,   0, 0, 1, 1, 0, 0, 0);
    add(2,    2, 1,   0, 0, 1, 1, 1, 0, 0);
    add(2,    3, 0,   1, 0, 1, 1, 1, 0, 0);
    add(2,   24, 0,   8, 0, 1, 1, 0, 0, 0);
    add(2,   30, 0,  10, 0, 0, 1, 0, 0, 0);
    add(2,   38, 1,  12, 0, 0, 1, 0, 0, 0);
    add(2,   39, 0,  13, 0, 1, 1, 0, 0, 0);
    add(2,   45, 0,   0, 1, 1, 1, 1, 1, 0);
    add(2,  180, 0,   0, 4, 1, 1, 0, 1, 0);
    add(2,  225, 0,   0, 5, 1, 0, 0, 1, 0);
    add(2,  315, 0,   0, 7, 1, 1, 0, 1, 0);
    add(2,  359, 1,  14, 7, 1, 1, 0, 0, 0);
    add(2,  360, 0,   0, 0, 1, 1, 1, 1, 1);
    add(2,  361, 0,   0, 0, 1, 1, 1, 0, 0);

    a_rst = 1'b1; a_en = 1'b1;
    b_rst = 1'b1; b_en = 1'b1;
    c_rst = 1'b1; c_en = 1'b1;
    repeat (3) step();
    chk_obs("reset_a", sample(0), mk_obs(0, 0, 0, 1, 1, 0, 0, 0));
    chk_obs("reset_b", sample(1), mk_obs(0, 0, 0, 0, 0, 0, 0, 0));
    chk_obs("reset_c", sample(2), mk_obs(0, 0, 0, 1, 1, 0, 0, 0));

    // Default build: first two lines
    a_rst = 1'b0;
    #1;
    check_table(0, 0);
    von_cnt = 0; hs_cnt = 0; ls1 = 0; ls2 = 0;
    for (int n = 1; n <= 3200; n++) begin
      step();
      check_table(0, n);
      if (n >= 1600 && n <= 3199) begin
        if (a_von) von_cnt++;
        if (!a_hs) hs_cnt++;
      end
      if (a_ls) begin
        if (n <= 1600) ls1++;
        else ls2++;
      end
    end
    chk("a_video_on_clocks", von_cnt, 1280);
    chk("a_hsync_low_clocks", hs_cnt, 192);
    chk("a_line_start_line0", ls1, 1);
    chk("a_line_start_line1", ls2, 1);

    // Freeze at x=300
    k = 0;
    while (a_x != 10'd300 && k < 2000) begin
      step();
      k++;
    end
    chk("a_reach_x300", a_x, 300);
    hs_hold = a_hs;
    a_en = 1'b0;
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (a_x != 10'd300 || a_y != 10'd2 || a_hs != hs_hold || !a_von ||
          a_tick || a_ls || a_fs) viol++;
      step();
    end
    chk("a_freeze_violations", viol, 0);
    a_en = 1'b1;
    step();
    step();
    chk("a_resume_x301", a_x, 301);
    step();
    chk("a_tick_before_drop", a_tick, 1);
    a_en = 1'b0;
    #1;
    chk("a_tick_gated", a_tick, 0);
    repeat (5) step();
    chk("a_hold_x301", a_x, 301);
    a_en = 1'b1;
    #1;
    chk("a_pending_tick", a_tick, 1);
    step();
    chk("a_resume_x302", a_x, 302);

    // Reset inside hsync
    k = 0;
    while (a_x != 10'd700 && k < 2000) begin
      step();
      k++;
    end
    chk("a_reach_x700", a_x, 700);
    chk("a_hsync_at_700", a_hs, 0);
    a_rst = 1'b1;
    step();
    chk_obs("a_reset_mid_line", sample(0), mk_obs(0, 0, 0, 1, 1, 0, 0, 0));
    a_rst = 1'b0;
    step();
    chk_obs("a_after_reset", sample(0), mk_obs(1, 0, 0, 1, 1, 1, 0, 0));
    a_rst = 1'b1;

    // PIX_DIV=1, active-high sync build
    b_rst = 1'b0;
    #1;
    check_table(1, 0);
    tick_low = 0; hs_hi = 0; ls_first = -1; ls_second = -1;
    for (int n = 1; n <= 1600; n++) begin
      step();
      check_table(1, n);
      if (!b_tick) tick_low++;
      if (n <= 800 && b_hs) hs_hi++;
      if (b_ls) begin
        if (ls_first < 0) ls_first = n;
        else if (ls_second < 0) ls_second = n;
      end
    end
    chk("b_tick_low_clocks", tick_low, 0);
    chk("b_hsync_active_clocks", hs_hi, 96);
    chk("b_line_period", ls_second - ls_first, 800);
    b_rst = 1'b1;

    // Small raster: two full frames
    c_rst = 1'b0;
    #1;
    check_table(2, 0);
    vs_cnt = 0; viol = 0; hs_cnt = 0; ls1 = 0; fs_cnt = 0;
    fs_first = -1; fs_second = -1;
    for (int n = 1; n <= 720; n++) begin
      step();
      check_table(2, n);
      if (n <= 360) begin
        if (!c_vs) vs_cnt++;
        if (c_ls) ls1++;
      end
      if (n <= 45 && !c_hs) hs_cnt++;
      if (c_von && c_y >= 10'd4) viol++;
      if (c_fs) begin
        fs_cnt++;
        if (!c_ls) viol++;
        if (fs_first < 0) fs_first = n;
        else if (fs_second < 0) fs_second = n;
      end
    end
    chk("c_vsync_low_clocks", vs_cnt, 90);
    chk("c_hsync_low_clocks", hs_cnt, 9);
    chk("c_line_starts_per_frame", ls1, 8);
    chk("c_frame_starts", fs_cnt, 2);
    chk("c_frame_period", fs_second - fs_first, 360);
    chk("c_blank_or_strobe_violations", viol, 0);
    c_rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the VGA output path from the board system clock.
- Generates the pixel-rate enable internally (divide-by-PIX_DIV, replacing a derived clock) and runs horizontal/vertical phase state machines.
- Drives hsync, vsync, video_on, the pixel coordinates and line/frame strobes to the pixel-generation logic and the DAC pins.
- Default timing: 640x480 @ 60 Hz from a 50 MHz clock.

Parameters:
PIX_DIV, 2, system clocks per pixel tick (>=1)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
enable  in  1  1 = timing runs; 0 = freeze counters and phases
pix_tick  out  1  one-clock pulse each pixel period; downstream pixel logic qualifies on it
hsync  out  1  horizontal sync, level per SYNC_ACTIVE
vsync  out  1  vertical sync, level per SYNC_ACTIVE
video_on  out  1  1 while in H_VISIBLE and V_VISIBLE region
x  out  10  current horizontal count (0..H_TOTAL-1)
y  out  10  current vertical count (0..V_TOTAL-1)
line_start  out  1  one-clock pulse when x wraps to 0
frame_start  out  1  one-clock pulse when (x,y) wraps to (0,0)

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Totals: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525). Counters are 10 bits; elaboration fails if either total exceeds 1024.
- Tick divider:
  - Counts 0..PIX_DIV-1 while enable=1.
  - pix_tick=1 on the cycle the divider is at PIX_DIV-1; the divider then returns to 0.
  - PIX_DIV=1: pix_tick=1 on every enabled cycle.
  - enable=0: divider holds its value and pix_tick=0.
- Advance occurs on a clock edge where pix_tick=1:
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0.
- Horizontal FSM states: H_VIS, H_FP, H_SY, H_BP.
  - H_VIS -> H_FP when x reaches H_VISIBLE (640).
  - H_FP -> H_SY at 656.
  - H_SY -> H_BP at 752.
  - H_BP -> H_VIS at wrap to 0.
- Vertical FSM states: V_VIS, V_FP, V_SY, V_BP, same pattern on y (480, 490, 492, wrap). It transitions only on the advance that wraps x.
- Output decode:
  - hsync = SYNC_ACTIVE while the horizontal state is H_SY, else ~SYNC_ACTIVE.
  - vsync is decoded the same way from V_SY.
  - video_on = (H_VIS && V_VIS).
  - All outputs are registered and decoded from next-state, so they are coherent with x,y in the same cycle (zero added latency).
- Strobes:
  - line_start: 1 for exactly the clock cycle following the advance that wrapped x to 0.
  - frame_start: same timing, only when y also wrapped to 0. It coincides with a line_start pulse.
- Reset:
  - Values: x=0, y=0, divider=0, states H_VIS/V_VIS, hsync=vsync=~SYNC_ACTIVE, video_on=0, pix_tick=0, line_start=0, frame_start=0.
  - First edge after reset deasserts: video_on=1 (region 0,0); no strobes.
- Reset mid-line or mid-frame: the next edge restores reset values unconditionally. No partial-sync pulse is extended.
- enable deasserted mid-frame: every output holds its value, except pix_tick/line_start/frame_start which are 0. Re-enable resumes the divider from its held value.
- reset and enable both high: reset wins.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480 timing constants;
  - H_TOTAL/V_TOTAL as derived localparams;
  - a 2-bit phase enum {VIS, FP, SY, BP} used by both FSMs.
- Sub-module vga_pixel_tick (parameter PIX_DIV; ports clock, reset, enable, pix_tick) holds the divider. It is reusable by the sprite/frame-buffer blocks.

Test Plan:
- Reset held 3 cycles then released, enable=1, defaults -> pix_tick toggles every 2nd clock; x=0,y=0, video_on=1, hsync=vsync=1 on the first edge.
- Run one line -> video_on high for exactly 640 ticks (1280 clocks). hsync low from x=656 to 751 (96 ticks, 192 clocks). line_start pulses once at x wrap 799->0.
- Run a full frame -> frame_start pulses after 420000 ticks (840000 clocks). vsync low exactly for y=490..491 (1600 ticks). No video_on during y>=480.
- Drop enable at x=300,y=100 for 50 clocks -> x,y, hsync and video_on frozen, pix_tick=0. After re-enable, x reaches 301 within PIX_DIV clocks.
- Assert reset at x=700 (inside hsync) -> next edge hsync=1, x=0, y=0, no line_start/frame_start pulse.
- PIX_DIV=1, SYNC_ACTIVE=1 build -> pix_tick constant high when enabled; hsync high (active) for x=656..751; line period 800 clocks.
